// File: rtl/cba_accum_32_if.sv
//------------------------------------------------------------------------------
// Module      : cba_accum_32_if
// Description : Stream bundle for cba_accum_32. The input side carries a
//               valid/ready stream of 32-bit words delimited by in_last. The
//               result side carries the {hi,lo} packet sum, the beat count and
//               the sticky overflow flag under a valid/ready handshake.
//               master : stream producer and result consumer
//               slave  : the accumulator
// Ports       : in_valid, in_ready, in_data[31:0], in_last,
//               out_valid, out_ready, out_sum_lo[31:0], out_sum_hi[HI_W-1:0],
//               out_count[CNT_W-1:0], out_ovf
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cba_accum_32_if #(
  parameter int HI_W  = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum_lo;
  logic [HI_W-1:0]  out_sum_hi;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum_lo, out_sum_hi, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum_lo, out_sum_hi, out_count, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/cba_accum_32.sv
//------------------------------------------------------------------------------
// Module      : cba_accum_32
// Description : Streaming packet accumulator. The low word is summed with a
//               32-bit carry-bypass adder (eight 4-bit ripple blocks, each
//               bypassing its carry when every bit propagates); the adder
//               carry-out increments the high word. One result per packet is
//               held on the result port until consumed.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               clear  - synchronous abort, drops the packet or pending result
//               bus    - cba_accum_32_if.slave (input stream + result port)
// Config      : CBA_ACC_SAT_EN defined  -> high-word overflow saturates the sum
//                                          to all-ones for the rest of the packet
//               CBA_ACC_SAT_EN undefined -> modular wrap of the full sum
//               Either way out_ovf is set and sticky until the next packet.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cba_accum_32 #(
  parameter int HI_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  cba_accum_32_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HI_W-1:0]  HI_MAX  = '1;

  state_t           state_q, state_d;
  logic [31:0]      acc_lo_q, acc_lo_d;
  logic [HI_W-1:0]  acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             in_ready;
  logic             accept;
  logic             hi_ovf;
  logic [CNT_W-1:0] count_inc;

  // Carry-bypass adder signals
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        blk_cin;
  logic        blk_rip;
  logic        blk_prop;
  logic        bit_p;
  logic        carry;

  // First beat of a packet forces operand a to zero so the sum is the beat.
  assign add_a = (state_q == S_ACCUM) ? acc_lo_q : 32'd0;
  assign add_b = bus.in_data;

  always_comb begin
    add_sum  = '0;
    carry    = 1'b0;
    blk_cin  = 1'b0;
    blk_rip  = 1'b0;
    blk_prop = 1'b0;
    bit_p    = 1'b0;
    for (int b = 0; b < 8; b++) begin
      blk_cin  = carry;
      blk_rip  = carry;
      blk_prop = 1'b1;
      for (int k = 0; k < 4; k++) begin
        bit_p              = add_a[4*b+k] ^ add_b[4*b+k];
        add_sum[4*b+k]     = bit_p ^ blk_rip;
        blk_rip            = (add_a[4*b+k] & add_b[4*b+k]) | (bit_p & blk_rip);
        blk_prop           = blk_prop & bit_p;
      end
      // A fully propagating block passes its carry-in straight through.
      carry = blk_prop ? blk_cin : blk_rip;
    end
    add_cout = carry;
  end

  assign in_ready  = (state_q != S_HOLD) & ~clear;
  assign accept    = bus.in_valid & in_ready;
  assign hi_ovf    = add_cout & (acc_hi_q == HI_MAX);
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      state_d  = S_IDLE;
      acc_lo_d = '0;
      acc_hi_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            if (state_q == S_IDLE) begin
              acc_lo_d = add_sum;
              acc_hi_d = '0;
              count_d  = CNT_W'(1);
              ovf_d    = 1'b0;
            end else begin
              count_d = count_inc;
`ifdef CBA_ACC_SAT_EN
              // ovf_q can only be set by an earlier saturation in this packet.
              if (ovf_q | hi_ovf) begin
                acc_lo_d = '1;
                acc_hi_d = '1;
                ovf_d    = 1'b1;
              end else begin
                acc_lo_d = add_sum;
                acc_hi_d = acc_hi_q + HI_W'(add_cout);
              end
`else
              acc_lo_d = add_sum;
              acc_hi_d = acc_hi_q + HI_W'(add_cout);
              ovf_d    = ovf_q | hi_ovf;
`endif
            end
            state_d = bus.in_last ? S_HOLD : S_ACCUM;
          end
        end
        S_HOLD: begin
          // Accumulator registers are retained after the transfer.
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == S_HOLD);
  assign bus.out_sum_lo = acc_lo_q;
  assign bus.out_sum_hi = acc_hi_q;
  assign bus.out_count  = count_q;
  assign bus.out_ovf    = ovf_q;

endmodule

`default_nettype wire
